// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver feeding a CPU-readable key register.
// Raw ps2_clk/ps2_data are synchronized, ps2_clk is glitch-filtered, and each
// filtered falling edge strobes one frame bit into an 11-bit frame FSM.
// Completed bytes land in key_word; the bus consumes the word with ack.
// Optional feature macro: PS2_KBD_DECODE_EN (E0/F0 prefix decoding into the
// extended/break flags). With the macro undefined every byte is emitted raw.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a start bit (data 0 on strobe)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking the stop bit and parity, emitting byte
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ack,
    output logic [15:0] key_word,
    output logic        frame_err
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic           clk_s1, clk_s2;
    logic           dat_s1, dat_s2;
    logic [FCW-1:0] filt_cnt;
    logic           filt_clk;
    logic           filt_clk_d;
    logic           strobe;

    state_t         state, state_nxt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           par_bit;
    logic           par_ok;
    logic [WDW-1:0] wd_cnt;
    logic           timeout;
    logic           byte_ok;
    logic           err_nxt;

    logic           emit;
    logic [15:0]    emit_word;

    // Two-flop synchronizers; both lines idle high on the PS/2 bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Stability filter: the filtered clock follows only after FILTER_LEN
    // consecutive cycles at the new level; any bounce restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            filt_cnt <= '0;
            filt_clk <= clk_s2;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Registered falling-edge detect of the filtered clock gives the bit strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_d <= 1'b1;
            strobe     <= 1'b0;
        end else begin
            filt_clk_d <= filt_clk;
            strobe     <= filt_clk_d & ~filt_clk;
        end
    end

    // Watchdog counts idle cycles between strobes while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == ST_IDLE || strobe) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (state != ST_IDLE) && !strobe &&
                     (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    assign par_ok  = ^{shift_reg, par_bit};

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next-state, byte-complete and error decode.
    always_comb begin
        state_nxt = state;
        byte_ok   = 1'b0;
        err_nxt   = 1'b0;
        if (timeout) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
        end else if (strobe) begin
            case (state)
                ST_IDLE: begin
                    if (!dat_s2) begin
                        state_nxt = ST_DATA;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    if (dat_s2 && par_ok) begin
                        byte_ok = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Frame datapath: bit counter, data shifter and parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else if (timeout) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (strobe) begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    shift_reg <= {dat_s2, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                ST_PARITY: begin
                    par_bit <= dat_s2;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PS2_KBD_DECODE_EN
    logic ext_flag;
    logic brk_flag;

    // Prefix flags: E0 marks extended, F0 marks break; consumed by the next
    // ordinary byte and dropped on any frame error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (err_nxt) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_ok) begin
            if (shift_reg == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (shift_reg == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    assign emit      = byte_ok && (shift_reg != 8'hE0) && (shift_reg != 8'hF0);
    assign emit_word = {1'b1, brk_flag, ext_flag, 1'b0, 4'b0000, shift_reg};
`else
    assign emit      = byte_ok;
    assign emit_word = {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, shift_reg};
`endif

    // Holding register and error pulse. A word arriving while the previous
    // one is still unread is dropped and flagged as overrun instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_word  <= 16'h0000;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_nxt;
            if (emit) begin
                if (ack || !key_word[15]) begin
                    key_word <= emit_word;
                end else begin
                    key_word[12] <= 1'b1;
                end
            end else if (ack) begin
                key_word <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: drives PS/2 frames, keeps an event-level
// model of the key register and error pulse, and compares every cycle.
module tb_ps2_keyboard_rx;

    localparam int F    = 4;
    localparam int T    = 300;
    localparam int HALF = 15;

    localparam int K_NONE = 0;
    localparam int K_BYTE = 1;
    localparam int K_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ack = 1'b0;
    logic [15:0] key_word;
    logic        frame_err;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_word = 16'h0000;
    logic        exp_ferr = 1'b0;
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    logic        mon_en = 1'b0;
    logic        skip_ferr = 1'b0;

    ps2_keyboard_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ack       (ack),
        .key_word  (key_word),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check("key_word", key_word, exp_word);
            if (!skip_ferr) check("frame_err", {15'd0, frame_err}, {15'd0, exp_ferr});
        end
    end

    // Model: a decoded byte from the frame layer.
    task automatic model_byte(input logic [7:0] c);
        logic        em;
        logic [15:0] w;
        em = 1'b1;
`ifdef PS2_KBD_DECODE_EN
        w = 16'h0000;
        if (c == 8'hE0) begin
            m_ext = 1'b1; em = 1'b0;
        end else if (c == 8'hF0) begin
            m_brk = 1'b1; em = 1'b0;
        end else begin
            w = {1'b1, m_brk, m_ext, 1'b0, 4'h0, c};
            m_ext = 1'b0; m_brk = 1'b0;
        end
`else
        w = {8'h80, c};
`endif
        if (em) begin
            if (exp_word[15]) exp_word[12] = 1'b1;
            else exp_word = w;
        end
    endtask

    task automatic model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_ack();
        if (exp_word[15]) exp_word = 16'h0000;
    endtask

    // One PS/2 bit: data set mid-high, then a falling clock edge. For the
    // final bit of an event, the model is updated on the cycle the key
    // register / error pulse must change (F+4 edges after the fall), with
    // optional ack raised in that same cycle.
    task automatic ps2_bit(input logic b, input int kind, input logic [7:0] code, input bit ack_now);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (kind != K_NONE) begin
            repeat (F + 3) @(posedge clk);
            @(negedge clk);
            ack = ack_now;
            @(posedge clk);
            #1;
            ack = 1'b0;
            if (ack_now) model_ack();
            if (kind == K_BYTE) begin
                model_byte(code);
            end else begin
                model_err();
                exp_ferr = 1'b1;
                @(posedge clk);
                #1;
                exp_ferr = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit par_ok, input bit stop_ok, input bit ack_now);
        logic p;
        p = par_ok ? ~^c : ^c;
        ps2_bit(1'b0, K_NONE, c, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i], K_NONE, c, 1'b0);
        ps2_bit(p, K_NONE, c, 1'b0);
        ps2_bit(stop_ok, (par_ok && stop_ok) ? K_BYTE : K_ERR, c, ack_now);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        model_ack();
        @(negedge clk);
    endtask

    initial begin : stim
        int  n;
        bit  got;
        logic [7:0] code;
        int  r;

        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_word", key_word, 16'h0000);
        check("reset_ferr", {15'd0, frame_err}, 16'h0000);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame and ack.
        send_frame(8'h1C, 1, 1, 0);
        check("lit_801C", key_word, 16'h801C);
        do_ack();
        check("lit_ack_0", key_word, 16'h0000);

        // Bad parity then good frame.
        send_frame(8'h1C, 0, 1, 0);
        check("lit_badpar", key_word, 16'h0000);
        send_frame(8'h1C, 1, 1, 0);
        check("lit_after_bad", key_word, 16'h801C);
        do_ack();

        // Overrun, then same-cycle ack and emit.
        send_frame(8'h1C, 1, 1, 0);
        send_frame(8'h32, 1, 1, 0);
        check("lit_901C", key_word, 16'h901C);
        do_ack();
        check("lit_ovr_clr", key_word, 16'h0000);
        send_frame(8'h1C, 1, 1, 0);
        send_frame(8'h32, 1, 1, 1);
        check("lit_8032", key_word, 16'h8032);
        do_ack();

        // Bad stop bit.
        send_frame(8'hA5, 1, 0, 0);
        check("lit_badstop", key_word, 16'h0000);

        // Watchdog: start plus 3 data bits, then stall with the clock low.
        ps2_bit(1'b0, K_NONE, 8'h00, 1'b0);
        ps2_bit(1'b1, K_NONE, 8'h00, 1'b0);
        ps2_bit(1'b0, K_NONE, 8'h00, 1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        skip_ferr = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < F + T + 40) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_err) got = 1'b1;
        end
        checks++;
        if (!got || n < F + 3 + T || n > F + 5 + T) begin
            failures++;
            $display("FAIL timeout_time: got %0d cycles (seen=%0d) expected %0d..%0d", n, got, F + 3 + T, F + 5 + T);
        end
        model_err();
        @(posedge clk);
        #1;
        check("timeout_width", {15'd0, frame_err}, 16'h0000);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        skip_ferr = 1'b0;
        send_frame(8'h29, 1, 1, 0);
        check("lit_8029", key_word, 16'h8029);
        do_ack();

        // Strobe in idle with data high is rejected.
        ps2_bit(1'b1, K_ERR, 8'h00, 1'b0);
        repeat (HALF) @(negedge clk);
        check("idle_err_word", key_word, 16'h0000);

        // Reset in the middle of a frame while a word is held.
        send_frame(8'h55, 1, 1, 0);
        check("lit_8055", key_word, 16'h8055);
        ps2_bit(1'b0, K_NONE, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], K_NONE, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_word = 16'h0000;
        model_err();
        repeat (3) begin
            @(negedge clk);
            check("in_reset_word", key_word, 16'h0000);
            check("in_reset_ferr", {15'd0, frame_err}, 16'h0000);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1, 1, 0);
        check("lit_post_rst", key_word, 16'h801C);
        do_ack();

`ifdef PS2_KBD_DECODE_EN
        send_frame(8'hE0, 1, 1, 0);
        check("lit_no_e0", key_word, 16'h0000);
        send_frame(8'hF0, 1, 1, 0);
        check("lit_no_f0", key_word, 16'h0000);
        send_frame(8'h75, 1, 1, 0);
        check("lit_E075", key_word, 16'hE075);
        do_ack();
`else
        send_frame(8'hE0, 1, 1, 0);
        check("lit_80E0", key_word, 16'h80E0);
        do_ack();
        send_frame(8'hF0, 1, 1, 0);
        check("lit_80F0", key_word, 16'h80F0);
        do_ack();
`endif

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 11);
            code = 8'($urandom);
            if ($urandom_range(0, 5) == 0) code = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0;
            if (r == 0) begin
                ps2_bit(1'b1, K_ERR, 8'h00, 1'b0);
                repeat (HALF) @(negedge clk);
            end else begin
                send_frame(code, r != 1, r != 2, $urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 1) == 0) do_ack();
        end

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives scan-code frames from a PS/2 keyboard and presents each decoded key event as one 16-bit word at the CPU's keyboard register. Provides the data side of the bus read/acknowledge exchange: the bus reads `key_word` and pulses `ack` to consume it. Sits between the board PS/2 pins and the memory-mapped I/O decode, in the `clk` domain.

## Interface
- `FILTER_LEN`, default 8: consecutive `clk` cycles that synchronized `ps2_clk` must hold a new level before the filtered clock changes.
- `TIMEOUT_CYCLES`, default 5000: idle `clk` cycles allowed between falling edges inside a frame before the frame is aborted.
- `clk` input 1: system clock; all state is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data, asynchronous to `clk`.
- `ack` input 1: one-cycle pulse from the bus read; consumes the held word.
- `key_word` output 16: held key event word.
  - Bit 15: valid.
  - Bit 14: break.
  - Bit 13: extended.
  - Bit 12: overrun.
  - Bits 11:8: zero.
  - Bits 7:0: scan code.
- `frame_err` output 1: one-cycle pulse on any rejected frame.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - Synchronized `ps2_clk` goes through the `FILTER_LEN` stability filter; the filtered clock resets to 1.
  - A registered filtered 1→0 transition is the sample strobe, and `ps2_data` is sampled on that strobe.
- **Frame state machine**
  - IDLE: on strobe, data 0 → DATA with bit count 0; data 1 → pulse `frame_err`, stay in IDLE.
  - DATA: shift bits in LSB first; after the 8th bit → PARITY.
  - PARITY: capture the bit; the frame requires odd parity over the 8 data bits plus the parity bit. Next state STOP.
  - STOP: stop bit 1 and parity good → byte complete; otherwise pulse `frame_err`. Either way → IDLE.
- **Watchdog**
  - The counter clears on every strobe.
  - In any state other than IDLE, reaching `TIMEOUT_CYCLES` pulses `frame_err`, returns to IDLE and discards partial bits.
- **Byte handling**: see Configuration.
- **Holding register**
  - An emitted word loads `key_word` with valid = 1, overrun = 0.
  - Emit while valid = 1 and no `ack` in the same cycle: the new word is dropped and overrun is set; it stays set until `ack`.
  - `ack` clears `key_word` to 16'h0000.
  - `ack` and emit in the same cycle: the new word loads, overrun = 0.
  - `ack` while valid = 0 has no effect.
- **Reset values**
  - `key_word` = 16'h0000 and `frame_err` = 0.
  - FSM in IDLE, filter output = 1, watchdog = 0, prefix flags = 0.
  - Reset mid-frame discards the partial frame.

## Timing
- The strobe follows a raw `ps2_clk` falling edge by 2 synchronizer cycles + `FILTER_LEN` + 1 cycles.
- `key_word` valid rises 1 cycle after the STOP-bit strobe.
- `frame_err` is asserted for exactly one cycle, 1 cycle after the offending strobe or watchdog expiry.
- `ack` takes effect on the next rising edge, and the read value is stable until then.
- Maximum accepted PS/2 clock is about 16.7 kHz, so `FILTER_LEN` must stay well under half a PS/2 bit time.

## Configuration
- Macro: `PS2_KBD_DECODE_EN`.
- **Defined**
  - Byte 8'hE0 sets the extended flag and 8'hF0 sets the break flag; neither emits a word.
  - Any other byte emits {1, brk, ext, 0, 4'b0, byte} and clears both flags.
  - `frame_err` also clears both flags.
- **Undefined**
  - Every byte, including E0 and F0, emits {1, 0, 0, 0, 4'b0, byte}.
  - Bits 14:13 are always 0.

## Test plan
- Frame 0x1C (parity 0, stop 1), then `ack` → `key_word` = 16'h801C, then 16'h0000 the cycle after `ack`.
- Macro defined, frames E0, F0, 75 → a single word 16'hE075; no word is emitted after E0 or after F0.
- Frame 0x1C with parity bit 1 → one `frame_err` pulse, `key_word` stays 16'h0000; a following good 0x1C → 16'h801C.
- Frames 0x1C, then 0x32 with no `ack` → 16'h901C.
  - `ack` → 16'h0000.
  - A second case has `ack` in the same cycle as the 0x32 emit → 16'h8032.
- Start bit plus 3 data bits, then stall → `frame_err` exactly `TIMEOUT_CYCLES` after the last strobe; next frame 0x29 → 16'h8029.
- `rst_n` low mid-frame (after 5 bits), then a full frame 0x1C → 16'h801C with no `frame_err`; all outputs are 0 while in reset.
